// File: rtl/cmd_reg_bank.sv
// Command-bus register bank: decodes one base window, commits accesses on the
// second pipeline edge and returns a fixed two-cycle acknowledge with read data.
module cmd_reg_bank #(
  parameter int unsigned          ADDR_BITS  = 20,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]          ID_VALUE   = 32'h0000_0000,
  parameter logic [31:0]          CTRL_RESET = 32'h0000_0000,
  parameter logic [31:0]          ERR_VALUE  = 32'hDEAD_BEEF
) (
  input  logic                 i_sys_clk,
  input  logic                 i_arst_n,
  input  logic                 i_cmd_sel,
  input  logic                 i_cmd_rd_wr_n,
  input  logic [ADDR_BITS-1:0] i_cmd_addr,
  input  logic [31:0]          i_cmd_wdata,
  output logic                 o_cmd_ack,
  output logic [31:0]          o_cmd_rdata,
  output logic [31:0]          o_ctrl,
  output logic [31:0]          o_pulse,
  input  logic [31:0]          i_status,
  input  logic [31:0]          i_sticky_set
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 4;

  localparam logic [OFF_W-1:0] OFF_ID      = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_SCRATCH = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_CTRL    = OFF_W'(2);
  localparam logic [OFF_W-1:0] OFF_PULSE   = OFF_W'(3);
  localparam logic [OFF_W-1:0] OFF_STATUS  = OFF_W'(4);
  localparam logic [OFF_W-1:0] OFF_STICKY  = OFF_W'(5);
  localparam logic [OFF_W-1:0] OFF_CMD_CNT = OFF_W'(6);

  typedef struct packed {
    logic              rd;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  logic              s1_vld_q,  s1_vld_d;
  cmd_t              s1_q,      s1_d;
  logic              ack_q,     ack_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic [DATA_W-1:0] pulse_q,   pulse_d;
  logic [DATA_W-1:0] ctrl_q,    ctrl_d;
  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic [DATA_W-1:0] sticky_q,  sticky_d;
  logic [DATA_W-1:0] cnt_q,     cnt_d;
  logic              hit;
  logic              wr_commit;

  // S1 capture of matched strobes; commit of S1 into architectural state.
  always_comb begin
    hit       = (i_cmd_addr[ADDR_BITS-1:OFF_W] == BASE_ADDR[ADDR_BITS-1:OFF_W]);
    s1_vld_d  = i_cmd_sel && hit;
    s1_d      = '{rd: i_cmd_rd_wr_n, off: i_cmd_addr[OFF_W-1:0], wdata: i_cmd_wdata};
    wr_commit = s1_vld_q && !s1_q.rd;

    ack_d     = s1_vld_q;
    rdata_d   = '0;
    pulse_d   = '0;
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;

    if (wr_commit) begin
      case (s1_q.off)
        OFF_SCRATCH: scratch_d = s1_q.wdata;
        OFF_CTRL:    ctrl_d    = s1_q.wdata;
        OFF_PULSE:   pulse_d   = s1_q.wdata;
        OFF_STICKY:  sticky_d  = sticky_q & ~s1_q.wdata;
        default:     ;
      endcase
    end
    // Set is applied after the clear so a coincident set wins.
    sticky_d = sticky_d | i_sticky_set;

    if (s1_vld_q) begin
      cnt_d = cnt_q + DATA_W'(1);
      if (s1_q.rd) begin
        case (s1_q.off)
          OFF_ID:      rdata_d = ID_VALUE;
          OFF_SCRATCH: rdata_d = scratch_q;
          OFF_CTRL:    rdata_d = ctrl_q;
          OFF_PULSE:   rdata_d = '0;
          OFF_STATUS:  rdata_d = i_status;
          OFF_STICKY:  rdata_d = sticky_q | i_sticky_set;
          OFF_CMD_CNT: rdata_d = cnt_q;
          default:     rdata_d = ERR_VALUE;
        endcase
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      pulse_q   <= '0;
      ctrl_q    <= CTRL_RESET;
      scratch_q <= '0;
      sticky_q  <= '0;
      cnt_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_q      <= s1_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      pulse_q   <= pulse_d;
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_cmd_ack   = ack_q;
  assign o_cmd_rdata = rdata_q;
  assign o_ctrl      = ctrl_q;
  assign o_pulse     = pulse_q;

endmodule
